// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for the ripple-adder sum.
// Optional macro SUM_BCD_FAST_EN: values below ten bypass the shift sequence and complete in one clock.
module sum_bcd_converter #(
    parameter int WIDTH  = 5,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      sum_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    generate
        if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
            $error("sum_bcd_converter: DIGITS too small to represent 2^WIDTH-1");
        end
    endgenerate

    // One double-dabble step: correct every BCD nibble >= 5 by +3, then shift left one bit.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        logic [3:0]      nib;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            nib = v[WIDTH + 4*d +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end else begin
                nib = nib;
            end
            r[WIDTH + 4*d +: 4] = nib;
        end
        return {r[SR_W-2:0], 1'b0};
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r,     state_s;
    logic [SR_W-1:0]    shift_r,     shift_s;
    logic [CNT_W-1:0]   count_r,     count_s;
    logic [BCD_W-1:0]   bcd_r,       bcd_s;
    logic               in_ready_r,  in_ready_s;
    logic               out_valid_r, out_valid_s;
    logic               busy_r,      busy_s;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        count_s = count_r;
        bcd_s   = bcd_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_s = SR_W'(sum_in);
                    count_s = CNT_W'(WIDTH);
                    state_s = ST_SHIFT;
`ifdef SUM_BCD_FAST_EN
                    if (32'(sum_in) < 32'd10) begin
                        bcd_s   = BCD_W'(sum_in);
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = dabble_step(shift_r);
                count_s = count_r - CNT_W'(1);
                if (count_r == CNT_W'(1)) begin
                    bcd_s   = shift_s[SR_W-1 -: BCD_W];
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        in_ready_s  = (state_s == ST_IDLE);
        busy_s      = (state_s == ST_SHIFT);
        out_valid_s = (state_s == ST_DONE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shift_r     <= '0;
            count_r     <= '0;
            bcd_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            count_r     <= count_s;
            bcd_r       <= bcd_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign bcd_out   = bcd_r;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Directed self-checking bench for sum_bcd_converter (default WIDTH=5, DIGITS=2).
module tb_sum_bcd_converter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] sum_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] bcd_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    sum_bcd_converter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int v);
`ifdef SUM_BCD_FAST_EN
        return (v < 10) ? 1 : 6;
`else
        return 6;
`endif
    endfunction

    // Accept one value, wait (bounded) for the result, check latency and digits, then return to IDLE.
    task automatic convert(input logic [4:0] v, input logic [7:0] exp_bcd, input string tag);
        int n;
        sum_in   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sum_in   = 5'($urandom);
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat(int'(v))));
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        tick();
        chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int s;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_in    = 5'd0;

        // Asynchronous reset asserted mid-cycle takes effect without a clock edge
        #12;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_bcd",       32'(bcd_out),       32'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single conversion of 15 with cycle-by-cycle busy tracking
        sum_in   = 5'd15;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sum_in   = 5'd3;
        for (int i = 0; i < 5; i++) begin
            chk("s15_busy",  {31'd0, busy},      32'd1);
            chk("s15_nrdy",  {31'd0, in_ready},  32'd0);
            chk("s15_novld", {31'd0, out_valid}, 32'd0);
            tick();
        end
        chk("s15_vld",  {31'd0, out_valid}, 32'd1);
        chk("s15_nbsy", {31'd0, busy},      32'd0);
        chk("s15_bcd",  32'(bcd_out),       32'h15);
        tick();
        chk("s15_idle",   {31'd0, in_ready},  32'd1);
        chk("s15_vlddn",  {31'd0, out_valid}, 32'd0);
        chk("s15_retain", 32'(bcd_out),       32'h15);

        // Boundary values
        convert(5'd0,  8'h00, "b0");
        convert(5'd9,  8'h09, "b9");
        convert(5'd10, 8'h10, "b10");
        convert(5'd31, 8'h31, "b31");

        // Backpressure: result held, new input ignored while DONE
        out_ready = 1'b0;
        sum_in    = 5'd12;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        chk("bp_vld", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            sum_in   = 5'd7;
            in_valid = 1'b1;
            tick();
            chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_bcd", 32'(bcd_out),       32'h12);
            chk("bp_nrdy",     {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_rdy", {31'd0, in_ready},  32'd1);
        chk("bp_release_vld", {31'd0, out_valid}, 32'd0);
        chk("bp_release_bcd", 32'(bcd_out),       32'h12);
        convert(5'd7, 8'h07, "bp7");

        // Reset during SHIFT cycle 3 discards the conversion
        sum_in   = 5'd23;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy",  {31'd0, busy},      32'd0);
        chk("mr_rdy",   {31'd0, in_ready},  32'd1);
        chk("mr_vld",   {31'd0, out_valid}, 32'd0);
        chk("mr_bcd",   32'(bcd_out),       32'h00);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_novld", {31'd0, out_valid}, 32'd0);
            chk("mr_bcd0",  32'(bcd_out),       32'h00);
        end
        convert(5'd23, 8'h23, "mr23");

        // Adder chain sweep, carry-in zero
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                s = a + b;
                convert(5'(s), 8'(((s / 10) * 16) + (s % 10)), "sweep");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
